vga_sync_rx: RTL

- VGA timing receiver and checker, the sink side of the demoscene VGA output (hsync/vsync plus 2-bit R/G/B per channel).
- Recovers pixel coordinates from the sync pulses and validates H/V timing against parameters.
- Declares lock and emits a per-pixel valid stream with the sampled colour.
- Used as an on-chip loopback monitor and as the bench scoreboard front-end for the VGA generator.

---
 rtl/vga_sync_rx_if.sv | 26 ++
 rtl/vga_sync_rx.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_rx_if.sv
// -----------------------------------------------------------------------------
// vga_sync_rx_if
// VGA link carrying the sync pulses and the 2-bit-per-channel colour from a
// VGA source to a receiver.
//
// Signals:
//   hsync  horizontal sync, active low
//   vsync  vertical sync, active low
//   vga_r  red   (2 bits)
//   vga_g  green (2 bits)
//   vga_b  blue  (2 bits)
//
// Modports:
//   master  the VGA source, which drives every signal
//   slave   the receiver, which samples every signal
// -----------------------------------------------------------------------------
interface vga_sync_rx_if;
  logic       hsync;
  logic       vsync;
  logic [1:0] vga_r;
  logic [1:0] vga_g;
  logic [1:0] vga_b;

  modport master (output hsync, output vsync, output vga_r, output vga_g, output vga_b);
  modport slave  (input  hsync, input  vsync, input  vga_r, input  vga_g, input  vga_b);
endinterface

// File: rtl/vga_sync_rx.sv
// -----------------------------------------------------------------------------
// vga_sync_rx
// VGA timing receiver and checker. It recovers pixel coordinates from the sync
// pulses, checks the H/V timing against the parameters, declares lock after
// one clean frame and emits a per-pixel valid stream with the sampled colour.
//
// Ports:
//   clk              pixel clock, same domain as the source
//   rst_n            synchronous active-low reset
//   vga              VGA link (slave modport): hsync, vsync, vga_r/g/b
//   locked           timing locked (registered)
//   pix_valid        pix_* hold a visible pixel (1 clk after its sample)
//   pix_x, pix_y     visible column / row, held while pix_valid is low
//   pix_rgb          {r,g,b} of the pixel, held while pix_valid is low
//   frame_start      one-cycle pulse per locked frame
//   err_pulse        one-cycle pulse on a timing violation while syncing/locked
//   lock_loss_count  saturating count of LOCKED->UNLOCKED transitions
//
// H_TOTAL and V_TOTAL must both be below 2048 and H_VISIBLE/V_VISIBLE must
// fit the 10-bit coordinate outputs.
// -----------------------------------------------------------------------------
module vga_sync_rx #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_PULSE   = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_PULSE   = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic                clk,
  input  logic                rst_n,
  vga_sync_rx_if.slave        vga,
  output logic                locked,
  output logic                pix_valid,
  output logic [9:0]          pix_x,
  output logic [9:0]          pix_y,
  output logic [5:0]          pix_rgb,
  output logic                frame_start,
  output logic                err_pulse,
  output logic [7:0]          lock_loss_count
);

  // ---------------------------------------------------------------------------
  // Derived timing constants
  // ---------------------------------------------------------------------------
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_PULSE + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_PULSE + V_BACK;
  localparam int unsigned H_START = H_PULSE + H_BACK;
  localparam int unsigned V_START = V_PULSE + V_BACK;

  localparam logic [10:0] C_H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] C_H_START = 11'(H_START);
  localparam logic [10:0] C_H_END   = 11'(H_START + H_VISIBLE);
  localparam logic [10:0] C_V_START = 11'(V_START);
  localparam logic [10:0] C_V_END   = 11'(V_START + V_VISIBLE);
  localparam logic [11:0] C_H_PULSE = 12'(H_PULSE);
  localparam logic [11:0] C_V_TOTAL = 12'(V_TOTAL);
  localparam logic [10:0] C_V_PULSE = 11'(V_PULSE);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'b00,
    ST_SYNCING  = 2'b01,
    ST_LOCKED   = 2'b10
  } state_t;

  // Saturating increment used by every 11-bit position/tally counter.
  function automatic logic [10:0] sat_inc11(input logic [10:0] value);
    logic [10:0] result;
    if (value == 11'h7FF) begin
      result = value;
    end else begin
      result = value + 11'd1;
    end
    return result;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t      r_state;
  logic        r_hs_prev;
  logic        r_vs_prev;
  logic [10:0] r_h_idx;
  logic [10:0] r_v_pos;
  logic [10:0] r_vlow_hf;
  logic        r_line_seen;
  logic        r_frame_seen;
  logic        r_locked;
  logic        r_pix_valid;
  logic [9:0]  r_pix_x;
  logic [9:0]  r_pix_y;
  logic [5:0]  r_pix_rgb;
  logic        r_frame_start;
  logic        r_err_pulse;
  logic [7:0]  r_lock_loss;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  state_t      w_state_next;
  logic        w_hf;
  logic        w_hr;
  logic        w_vf;
  logic        w_vr;
  logic [10:0] w_h_idx;
  logic [10:0] w_v_pos;
  logic [10:0] w_vlow_hf;
  logic [11:0] w_hs_width;
  logic [11:0] w_frame_lines;
  logic        w_err_a;
  logic        w_err_b;
  logic        w_err_c;
  logic        w_err_d;
  logic        w_err_e;
  logic        w_err;
  logic        w_visible;
  logic        w_emit;
  logic [9:0]  w_pix_x;
  logic [9:0]  w_pix_y;
  logic [5:0]  w_rgb;

  // Edges are taken between the previous and the current sample, so the
  // previous-sample registers reset high and the first cycle sees no edge.
  assign w_hf = r_hs_prev & ~vga.hsync;
  assign w_hr = ~r_hs_prev & vga.hsync;
  assign w_vf = r_vs_prev & ~vga.vsync;
  assign w_vr = ~r_vs_prev & vga.vsync;

  assign w_rgb = {vga.vga_r, vga.vga_g, vga.vga_b};

  // Position of the current sample: h restarts on HF, v restarts on VF (which
  // wins over a simultaneous HF) and otherwise steps on each HF; the vsync-low
  // tally counts HFs seen on samples where vsync is low.
  always_comb begin
    w_h_idx   = r_h_idx;
    w_v_pos   = r_v_pos;
    w_vlow_hf = r_vlow_hf;
    if (w_hf) begin
      w_h_idx = 11'd0;
    end else begin
      w_h_idx = sat_inc11(r_h_idx);
    end
    if (w_vf) begin
      w_v_pos = 11'd0;
    end else if (w_hf) begin
      w_v_pos = sat_inc11(r_v_pos);
    end else begin
      w_v_pos = r_v_pos;
    end
    if (vga.vsync == 1'b0) begin
      if (w_vf) begin
        w_vlow_hf = w_hf ? 11'd1 : 11'd0;
      end else if (w_hf) begin
        w_vlow_hf = sat_inc11(r_vlow_hf);
      end else begin
        w_vlow_hf = r_vlow_hf;
      end
    end else begin
      w_vlow_hf = r_vlow_hf;
    end
  end

  // The hsync low run always starts at the HF sample (index 0), so its width
  // at HR is the previous sample's index plus one.
  assign w_hs_width = {1'b0, r_h_idx} + 12'd1;

  // v_pos restarts at every VF and then counts HFs, so at the next VF it plus
  // any HF on that very sample is the HF count of the closing frame.
  assign w_frame_lines = {1'b0, r_v_pos} + {11'd0, w_hf};

  // Timing violation detectors.
  assign w_err_a = w_hr & (w_hs_width != C_H_PULSE);
  assign w_err_b = w_hf & r_line_seen & (r_h_idx != C_H_LAST);
  // h_idx steps onto H_TOTAL exactly once per missing HF, so this fires once.
  assign w_err_c = ~w_hf & (r_h_idx == C_H_LAST);
  assign w_err_d = w_vf & r_frame_seen & (w_frame_lines != C_V_TOTAL);
  assign w_err_e = w_vr & (r_vlow_hf != C_V_PULSE);
  assign w_err   = w_err_a | w_err_b | w_err_c | w_err_d | w_err_e;

  // Visible window of the current sample and its coordinates. The visible
  // extent fits 10 bits, so the subtraction is done modulo 1024.
  assign w_visible = (w_h_idx >= C_H_START) && (w_h_idx < C_H_END) &&
                     (w_v_pos >= C_V_START) && (w_v_pos < C_V_END);
  assign w_pix_x   = w_h_idx[9:0] - C_H_START[9:0];
  assign w_pix_y   = w_v_pos[9:0] - C_V_START[9:0];
  assign w_emit    = w_visible & (r_state == ST_LOCKED);

  // Lock FSM next state; an error outranks a simultaneous VF, and that VF is
  // consumed without re-arming.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_vf) begin
          w_state_next = ST_SYNCING;
        end else begin
          w_state_next = ST_UNLOCKED;
        end
      end
      ST_SYNCING: begin
        if (w_err) begin
          w_state_next = ST_UNLOCKED;
        end else if (w_vf) begin
          w_state_next = ST_LOCKED;
        end else begin
          w_state_next = ST_SYNCING;
        end
      end
      ST_LOCKED: begin
        if (w_err) begin
          w_state_next = ST_UNLOCKED;
        end else begin
          w_state_next = ST_LOCKED;
        end
      end
      default: begin
        w_state_next = ST_UNLOCKED;
      end
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_UNLOCKED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Sync history, position counters and the line/frame-seen flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hs_prev    <= 1'b1;
      r_vs_prev    <= 1'b1;
      r_h_idx      <= 11'd0;
      r_v_pos      <= 11'd0;
      r_vlow_hf    <= 11'd0;
      r_line_seen  <= 1'b0;
      r_frame_seen <= 1'b0;
    end else begin
      r_hs_prev <= vga.hsync;
      r_vs_prev <= vga.vsync;
      r_h_idx   <= w_h_idx;
      r_v_pos   <= w_v_pos;
      r_vlow_hf <= w_vlow_hf;
      if (w_hf) begin
        r_line_seen <= 1'b1;
      end
      if (w_vf) begin
        r_frame_seen <= 1'b1;
      end
    end
  end

  // Registered status outputs: lock flag, frame/err pulses, lock-loss count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_locked      <= 1'b0;
      r_frame_start <= 1'b0;
      r_err_pulse   <= 1'b0;
      r_lock_loss   <= 8'd0;
    end else begin
      // Taken from the next state so locked rises one clock after the VF.
      r_locked      <= (w_state_next == ST_LOCKED);
      r_frame_start <= w_vf & (w_state_next == ST_LOCKED);
      // Errors seen while unlocked are not reported.
      r_err_pulse   <= w_err & (r_state != ST_UNLOCKED);
      if ((r_state == ST_LOCKED) && (w_state_next == ST_UNLOCKED) &&
          (r_lock_loss != 8'hFF)) begin
        r_lock_loss <= r_lock_loss + 8'd1;
      end
    end
  end

  // Registered pixel stream; coordinates and colour hold between pixels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pix_valid <= 1'b0;
      r_pix_x     <= 10'd0;
      r_pix_y     <= 10'd0;
      r_pix_rgb   <= 6'd0;
    end else begin
      r_pix_valid <= w_emit;
      if (w_emit) begin
        r_pix_x   <= w_pix_x;
        r_pix_y   <= w_pix_y;
        r_pix_rgb <= w_rgb;
      end
    end
  end

  assign locked          = r_locked;
  assign pix_valid       = r_pix_valid;
  assign pix_x           = r_pix_x;
  assign pix_y           = r_pix_y;
  assign pix_rgb         = r_pix_rgb;
  assign frame_start     = r_frame_start;
  assign err_pulse       = r_err_pulse;
  assign lock_loss_count = r_lock_loss;

endmodule
